ks_adder_pipe: RTL

- Parametrised, pipelined Kogge-Stone prefix adder/subtractor; next generation of the team's combinational 16-bit KS benchmark adder.
- Adds configurable width, configurable prefix levels per pipeline stage, carry-in, subtract mode, signed-overflow flag and a valid/ready stream handshake with back-pressure.
- Sits between dataset-driven stimulus and the output logger in ALS benchmark flows; also serves as the exact golden for approximate variants.

---
 rtl/ks_adder_pipe.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready stream handshake.
// Carry-in sits at prefix position 0; bit i of the operands sits at position i+1,
// so WIDTH positions and ceil(log2(WIDTH)) levels give every carry the sum needs.
// The carry out of the MSB is formed from the MSB generate/propagate in the last group.
// Latency is 1 + ceil(L / STAGE_LEVELS) cycles.
module ks_adder_pipe #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned STAGE_LEVELS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             sub,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH:0]   out0,
  output logic             ovf
);

  localparam int L  = $clog2(WIDTH);
  localparam int SL = int'(STAGE_LEVELS);
  // Number of prefix register groups; the stage-0 prep register feeds group 0.
  localparam int NG = (L + SL - 1) / SL;

  logic en;

  // Operand prep
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] gv_in;
  logic [WIDTH-1:0] pv_in;
  logic             c0;

  // Per-group input registers: prefix G/P, original p, and MSB/sign info
  logic [WIDTH-1:0] g_q  [NG];
  logic [WIDTH-1:0] p_q  [NG];
  logic [WIDTH-1:0] po_q [NG];
  logic [NG-1:0]    vld_q;
  logic [NG-1:0]    gm_q;
  logic [NG-1:0]    am_q;
  logic [NG-1:0]    bm_q;

  // Per-group prefix outputs
  logic [WIDTH-1:0] g_nx [NG];
  logic [WIDTH-1:0] p_nx [NG];
  logic [WIDTH-1:0] g_t;
  logic [WIDTH-1:0] p_t;

  // Final sum stage
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  logic [WIDTH:0]   out_q;
  logic             ovf_q;
  logic             vout_q;

  // Whole pipeline advances together; a stalled full output freezes every stage
  assign en        = ~vout_q | ready_out;
  assign ready_in  = en;
  assign valid_out = vout_q;
  assign out0      = out_q;
  assign ovf       = ovf_q;

  // Operand prep: invert B and force carry-in for subtraction, then map to positions
  always_comb begin
    b_op  = sub ? ~in1 : in1;
    c0    = sub | cin;
    g_in  = in0 & b_op;
    p_in  = in0 ^ b_op;
    gv_in = {g_in[WIDTH-2:0], c0};
    pv_in = {p_in[WIDTH-2:0], 1'b0};
  end

  // Prefix levels for every group, each reading that group's input register
  always_comb begin
    g_t = '0;
    p_t = '0;
    for (int s = 0; s < NG; s++) begin
      g_t = g_q[s];
      p_t = p_q[s];
      for (int k = 0; k < SL; k++) begin
        int lvl;
        int span;
        lvl  = s * SL + k;
        span = 1 << lvl;
        if (lvl < L) begin
          // Descending order keeps the lower operand at its pre-level value
          for (int i = WIDTH - 1; i >= span; i--) begin
            g_t[i] = g_t[i] | (p_t[i] & g_t[i - span]);
            p_t[i] = p_t[i] & p_t[i - span];
          end
        end
      end
      g_nx[s] = g_t;
      p_nx[s] = p_t;
    end
  end

  // Sum, carry-out and signed overflow from the last group's carries
  always_comb begin
    sum_c  = po_q[NG-1] ^ g_nx[NG-1];
    cout_c = gm_q[NG-1] | (po_q[NG-1][WIDTH-1] & g_nx[NG-1][WIDTH-1]);
    ovf_c  = (am_q[NG-1] == bm_q[NG-1]) & (sum_c[WIDTH-1] != am_q[NG-1]);
  end

  // Pipeline registers; data only loads behind a valid token so bubbles leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NG; s++) begin
        g_q[s]  <= '0;
        p_q[s]  <= '0;
        po_q[s] <= '0;
      end
      vld_q  <= '0;
      gm_q   <= '0;
      am_q   <= '0;
      bm_q   <= '0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
      vout_q <= 1'b0;
    end else if (en) begin
      vld_q[0] <= valid_in;
      if (valid_in) begin
        g_q[0]  <= gv_in;
        p_q[0]  <= pv_in;
        po_q[0] <= p_in;
        gm_q[0] <= g_in[WIDTH-1];
        am_q[0] <= in0[WIDTH-1];
        bm_q[0] <= b_op[WIDTH-1];
      end
      for (int s = 1; s < NG; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          g_q[s]  <= g_nx[s-1];
          p_q[s]  <= p_nx[s-1];
          po_q[s] <= po_q[s-1];
          gm_q[s] <= gm_q[s-1];
          am_q[s] <= am_q[s-1];
          bm_q[s] <= bm_q[s-1];
        end
      end
      vout_q <= vld_q[NG-1];
      if (vld_q[NG-1]) begin
        out_q <= {cout_c, sum_c};
        ovf_q <= ovf_c;
      end
    end
  end

endmodule
